// File: rtl/fir_ctrl.sv
// fir_ctrl: host-side sequencer for an NTAPS-tap FIR engine.
// Loads NTAPS coefficients, then NTAPS samples, then runs the engine for a
// host-specified number of compute cycles. Every output is registered.
module fir_ctrl #(
  parameter int NTAPS = 16,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [1:0]   s_cmd,
  input  logic [W-1:0] s_data,
  input  logic         abort,
  output logic         fir_wind,
  output logic         fir_load,
  output logic         fir_in_valid,
  output logic [W-1:0] fir_data,
  output logic         done,
  output logic         err
);

  localparam int CW = $clog2(NTAPS + 1);
  localparam logic [CW-1:0] FULL = CW'(NTAPS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] CMD_COEF = 2'b00;
  localparam logic [1:0] CMD_SAMP = 2'b01;
  localparam logic [1:0] CMD_RUN  = 2'b10;

  state_t        state_q, state_d;
  logic [CW-1:0] coef_cnt, coef_cnt_d;
  logic [CW-1:0] samp_cnt, samp_cnt_d;
  // Compute cycles still to follow the current fir_in_valid cycle.
  logic [W-1:0]  run_cnt, run_cnt_d;
  logic          s_ready_d, fir_wind_d, fir_load_d, fir_in_valid_d;
  logic          done_d, err_d;
  logic [W-1:0]  fir_data_d;
  logic          accept;

  assign accept = s_valid && s_ready;

  // Next-state and next-output decode.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d        = state_q;
    coef_cnt_d     = coef_cnt;
    samp_cnt_d     = samp_cnt;
    run_cnt_d      = run_cnt;
    fir_data_d     = fir_data;
    fir_wind_d     = 1'b0;
    fir_load_d     = 1'b0;
    fir_in_valid_d = 1'b0;
    done_d         = 1'b0;
    err_d          = 1'b0;

    if (abort) begin
      // Abort wins over everything, including a same-cycle handshake.
      state_d    = IDLE;
      coef_cnt_d = '0;
      samp_cnt_d = '0;
      run_cnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            unique case (s_cmd)
              CMD_COEF: begin
                if (coef_cnt < FULL && samp_cnt == '0) begin
                  fir_wind_d = 1'b1;
                  fir_data_d = s_data;
                  coef_cnt_d = coef_cnt + CW'(1);
                end else begin
                  err_d = 1'b1;
                end
              end
              CMD_SAMP: begin
                if (coef_cnt == FULL && samp_cnt < FULL) begin
                  fir_load_d = 1'b1;
                  fir_data_d = s_data;
                  samp_cnt_d = samp_cnt + CW'(1);
                end else begin
                  err_d = 1'b1;
                end
              end
              CMD_RUN: begin
                if (coef_cnt == FULL && samp_cnt == FULL) begin
                  if (s_data == '0) begin
                    // Zero-length run: report completion without computing.
                    done_d     = 1'b1;
                    samp_cnt_d = '0;
                  end else begin
                    state_d        = RUN;
                    fir_in_valid_d = 1'b1;
                    run_cnt_d      = s_data - W'(1);
                  end
                end else begin
                  err_d = 1'b1;
                end
              end
              default: err_d = 1'b1;
            endcase
          end
        end
        RUN: begin
          if (run_cnt != '0) begin
            fir_in_valid_d = 1'b1;
            run_cnt_d      = run_cnt - W'(1);
          end else begin
            // Coefficients are kept so the next sample set can reuse them.
            done_d     = 1'b1;
            samp_cnt_d = '0;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    s_ready_d = (state_d == IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= IDLE;
      coef_cnt     <= '0;
      samp_cnt     <= '0;
      run_cnt      <= '0;
      s_ready      <= 1'b0;
      fir_wind     <= 1'b0;
      fir_load     <= 1'b0;
      fir_in_valid <= 1'b0;
      fir_data     <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      state_q      <= state_d;
      coef_cnt     <= coef_cnt_d;
      samp_cnt     <= samp_cnt_d;
      run_cnt      <= run_cnt_d;
      s_ready      <= s_ready_d;
      fir_wind     <= fir_wind_d;
      fir_load     <= fir_load_d;
      fir_in_valid <= fir_in_valid_d;
      fir_data     <= fir_data_d;
      done         <= done_d;
      err          <= err_d;
    end
  end

endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: table-driven bench for fir_ctrl. Each vector carries the
// inputs for one cycle and the outputs expected right after the next edge.
module tb_fir_ctrl;
  localparam int NTAPS = 16;
  localparam int W     = 16;
  localparam int OW    = W + 6;

  logic         clk = 1'b0;
  logic         rstb;
  logic         s_valid;
  logic         s_ready;
  logic [1:0]   s_cmd;
  logic [W-1:0] s_data;
  logic         abort;
  logic         fir_wind, fir_load, fir_in_valid, done, err;
  logic [W-1:0] fir_data;

  fir_ctrl #(.NTAPS(NTAPS), .W(W)) dut (
    .clk(clk), .rstb(rstb), .s_valid(s_valid), .s_ready(s_ready),
    .s_cmd(s_cmd), .s_data(s_data), .abort(abort),
    .fir_wind(fir_wind), .fir_load(fir_load), .fir_in_valid(fir_in_valid),
    .fir_data(fir_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [1:0]    cmd;
    logic [W-1:0]  d;
    logic          ab;
    logic [OW-1:0] exp;
    string         name;
  } vec_t;

  vec_t          vecs[$];
  logic [OW-1:0] sb[$];
  logic [W-1:0]  exp_fd;
  int            total = 0;
  int            bad   = 0;

  // Output word layout: {s_ready, wind, load, in_valid, done, err, fir_data}.
  function automatic logic [OW-1:0] outs();
    return {s_ready, fir_wind, fir_load, fir_in_valid, done, err, fir_data};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got rdy/wind/load/inv/done/err=%b data=%h, expected %b data=%h",
               name, act[OW-1:W], act[W-1:0], exp[OW-1:W], exp[W-1:0]);
    end
  endtask

  task automatic add(input logic v, input logic [1:0] cmd, input logic [W-1:0] d,
                     input logic ab, input logic rdy, input logic wind,
                     input logic load, input logic inv, input logic dn,
                     input logic er, input string name);
    vec_t r;
    if (wind || load) exp_fd = d;
    r.v = v; r.cmd = cmd; r.d = d; r.ab = ab; r.name = name;
    r.exp = {rdy, wind, load, inv, dn, er, exp_fd};
    vecs.push_back(r);
  endtask

  task automatic coef(input logic [W-1:0] d, input string name);
    add(1'b1, 2'b00, d, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, name);
  endtask

  task automatic samp(input logic [W-1:0] d, input string name);
    add(1'b1, 2'b01, d, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, name);
  endtask

  task automatic quiet(input string name);
    add(1'b0, 2'b00, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, name);
  endtask

  task automatic computing(input string name);
    add(1'b0, 2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, name);
  endtask

  // Drive every queued vector; expected word enters the scoreboard when its
  // stimulus is driven and is popped once the DUT has clocked it.
  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      s_valid = vecs[i].v;
      s_cmd   = vecs[i].cmd;
      s_data  = vecs[i].d;
      abort   = vecs[i].ab;
      sb.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      check(vecs[i].name, outs(), sb.pop_front());
    end
    vecs.delete();
    @(negedge clk);
    s_valid = 1'b0;
    abort   = 1'b0;
  endtask

  initial begin
    rstb = 1'b0; s_valid = 1'b0; s_cmd = '0; s_data = '0; abort = 1'b0;
    exp_fd = '0;
    #12;
    check("reset_state", outs(), '0);
    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", outs(), {1'b1, 5'b0, {W{1'b0}}});

    // Coefficients all 1, then an illegal 17th coefficient.
    for (int i = 0; i < NTAPS; i++) coef(W'(1), $sformatf("coef%0d", i));
    add(1'b1, 2'b00, W'(16'h77), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "coef17_err");
    // 15 samples, then a premature run is rejected.
    for (int i = 1; i < NTAPS; i++) samp(W'(i), $sformatf("samp%0d", i));
    add(1'b1, 2'b10, W'(6), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "run_short_err");
    quiet("run_short_no_inv");
    samp(W'(16), "samp16");
    // Run 6: six compute cycles then done.
    add(1'b1, 2'b10, W'(6), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "run6_c1");
    for (int i = 2; i <= 6; i++) computing($sformatf("run6_c%0d", i));
    add(1'b0, 2'b00, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "run6_done");
    // New samples right after done, with a gap after every word.
    for (int i = 0; i < NTAPS; i++) begin
      samp(W'(101 + i), $sformatf("gap_samp%0d", i));
      quiet($sformatf("gap_idle%0d", i));
    end
    add(1'b1, 2'b11, W'(9), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "reserved_err");
    add(1'b1, 2'b10, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "run0_done");
    quiet("run0_after");
    // Run 100 aborted during compute cycle 10.
    for (int i = 0; i < NTAPS; i++) samp(W'(201 + i), $sformatf("rsamp%0d", i));
    add(1'b1, 2'b10, W'(100), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "run100_c1");
    for (int i = 2; i <= 10; i++) computing($sformatf("run100_c%0d", i));
    add(1'b0, 2'b00, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "abort_stop");
    for (int i = 0; i < 3; i++) quiet($sformatf("abort_no_done%0d", i));
    add(1'b1, 2'b00, W'(5), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "abort_drops_word");
    coef(W'(7), "coef_after_abort");
    for (int i = 1; i < NTAPS; i++) coef(W'(7), $sformatf("recoef%0d", i));
    for (int i = 0; i < NTAPS; i++) samp(W'(300 + i), $sformatf("msamp%0d", i));
    add(1'b1, 2'b10, W'(50), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "run50_c1");
    for (int i = 2; i <= 4; i++) computing($sformatf("run50_c%0d", i));
    run_table();

    // Asynchronous reset in the middle of a run.
    rstb = 1'b0;
    #1;
    check("async_reset_mid_run", outs(), '0);
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_mid_reset", outs(), {1'b1, 5'b0, {W{1'b0}}});

    exp_fd = '0;
    for (int i = 0; i < NTAPS; i++) coef(W'(3), $sformatf("pcoef%0d", i));
    for (int i = 0; i < NTAPS; i++) samp(W'(400 + i), $sformatf("psamp%0d", i));
    add(1'b1, 2'b10, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "post_reset_run0");
    quiet("post_reset_quiet");
    run_table();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
